spi_xfer_sched: RTL and testbench
=================================

Name: spi_xfer_sched

Overview:
- Multi-requester transfer scheduler in front of the APB SPI master core.
- Arbitrates round-robin between NREQ client ports and acts as APB master to the SPI core.
- Per transfer: programs DIVIDER, SS, TX0 and CTRL (GO set), waits for the core IRQ, reads RX0, and returns the received word to the granted client.
- Gives clients a simple req/done handshake so they never touch SPI registers directly.

Parameters:
NREQ, 2, number of requesting clients (2..8)
TIMEOUT, 65535, max PCLK cycles to wait for IRQ after GO write before abort
ADDR_RX0_TX0, 5'h00, SPI core RX0/TX0 register address
ADDR_CTRL, 5'h10, SPI core CTRL register address
ADDR_DIV, 5'h14, SPI core DIVIDER register address
ADDR_SS, 5'h18, SPI core SS register address

Ports:
PCLK  in  1  clock
PRESETN  in  1  reset
req  in  NREQ  per-client request, level, held until done
req_data  in  NREQ*32  per-client TX word (slice i = bits 32i+31:32i)
req_ss  in  NREQ*8  per-client slave-select mask
req_len  in  NREQ*7  per-client char_len (0 = 128 bits per core encoding; only RX0 is returned)
cfg_div  in  16  SPI clock divider value
cfg_mode  in  3  {lsb, tx_negedge, rx_negedge}
done  out  NREQ  one-cycle completion pulse to the granted client
err  out  1  qualifies done: 1 = timeout abort
rsp_data  out  32  RX0 word, valid while done asserted
busy  out  1  transfer sequence in progress
m_paddr  out  5  APB address to SPI core
m_pwdata  out  32  APB write data
m_pwrite  out  1  APB write
m_psel  out  1  APB select
m_penable  out  1  APB enable
m_prdata  in  32  APB read data
m_pready  in  1  APB ready
spi_irq  in  1  SPI core interrupt

Behaviour:
- Reset: PRESETN async, active-low; clock PCLK.
- All outputs 0 in reset: done, err, rsp_data, busy, m_* all 0.
- Round-robin pointer resets to client 0. FSM resets to IDLE.
- APB master protocol:
  - Each register access is SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1), held until m_pready=1.
  - paddr, pwdata and pwrite stay stable across SETUP/ACCESS.
  - m_psel/m_penable drop to 0 the cycle after m_pready.
- Arbitration:
  - In IDLE, grant the first asserted req at or after index (last_grant+1) mod NREQ.
  - The granted index, req_data, req_ss, req_len, cfg_div and cfg_mode are latched at grant. Later input changes have no effect on the current transfer.
  - Requests arriving mid-transfer wait; there is no preemption.
- States and transitions:
  - IDLE → WR_DIV when any req is asserted.
  - WR_DIV: write {16'b0, cfg_div} to ADDR_DIV.
  - WR_SS: write {24'b0, ss} to ADDR_SS.
  - WR_TX: write data to ADDR_RX0_TX0.
  - WR_CTRL: write to ADDR_CTRL: bit13 ass=1, bit12 ie=1, bit11 lsb, bit10 tx_neg, bit9 rx_neg, bit8 go=1, bits6:0 len, all other bits 0.
  - WAIT_IRQ: m_psel=0; timeout counter cleared on entry, increments each cycle.
    - spi_irq=1 → RD_RX.
    - counter == TIMEOUT-1 with no IRQ → ABORT.
  - RD_RX: read ADDR_RX0_TX0. m_prdata is captured into rsp_data in the ACCESS cycle where m_pready=1.
    - The read also clears the core IRQ.
  - RESP: done[grant]=1 for exactly one cycle, err=0. Then IDLE.
  - ABORT: write 32'h0000_2000 to ADDR_CTRL (go=0). Then done[grant]=1 with err=1 and rsp_data=0, then IDLE.
- busy=1 from the grant cycle through the RESP/ABORT done cycle inclusive.
- The scheduler sequences back-to-back transfers without re-checking IRQ polarity. IRQ must be low in WAIT_IRQ entry; a stale high IRQ is cleared by the preceding RD_RX.
- A client deasserting req mid-transfer does not cancel it; done is still pulsed.
- Reset asserted mid-sequence: immediate return to reset values. The APB transaction is abandoned (psel/penable low).

Test Plan:
- Single client 0: req_data=32'hA5A5_00FF, ss=8'h01, len=8, div=2, core echoes MISO=MOSI → APB writes, in order: DIV=0x2, SS=0x1, TX0=0xA5A500FF, CTRL=0x3108. After IRQ → RX0 read, done[0] pulse, err=0, rsp_data=32'h0000_00FF.
- Clients 0 and 1 requesting simultaneously, twice, last_grant=0 → grant order 1,0,1,0. Each done follows its own CTRL/GO write; no overlap of busy windows.
- APB wait states: slave holds m_pready low 3 cycles per access → paddr/pwdata/psel/penable stable throughout; register write sequence unchanged.
- spi_irq never asserted, TIMEOUT=16 → exactly 16 cycles in WAIT_IRQ, then CTRL write 0x2000, done pulse with err=1 and rsp_data=0.
- PRESETN pulled low during WR_TX ACCESS → all outputs 0 next evaluation. After release, a pending req restarts from WR_DIV with the round-robin pointer at 0.

Source files
------------

// File: rtl/spi_xfer_sched.sv
// Round-robin transfer scheduler that drives an APB SPI master core on behalf of NREQ clients.
// Each grant runs DIV/SS/TX/CTRL writes, waits for the core IRQ (or times out), then returns RX0.
module spi_xfer_sched #(
  parameter int         NREQ         = 2,
  parameter int         TIMEOUT      = 65535,
  parameter logic [4:0] ADDR_RX0_TX0 = 5'h00,
  parameter logic [4:0] ADDR_CTRL    = 5'h10,
  parameter logic [4:0] ADDR_DIV     = 5'h14,
  parameter logic [4:0] ADDR_SS      = 5'h18
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_data,
  input  logic [NREQ*8-1:0] req_ss,
  input  logic [NREQ*7-1:0] req_len,
  input  logic [15:0]       cfg_div,
  input  logic [2:0]        cfg_mode,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic [4:0]        m_paddr,
  output logic [31:0]       m_pwdata,
  output logic              m_pwrite,
  output logic              m_psel,
  output logic              m_penable,
  input  logic [31:0]       m_prdata,
  input  logic              m_pready,
  input  logic              spi_irq
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_CTRL,
    S_WAIT_IRQ, S_RD_RX, S_RESP, S_ABORT, S_ABORT_DONE
  } state_t;

  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t          state, next_state;
  phase_t          phase, next_phase;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   arb_idx;
  logic            arb_hit;
  logic [31:0]     data_q;
  logic [7:0]      ss_q;
  logic [6:0]      len_q;
  logic [15:0]     div_q;
  logic [2:0]      mode_q;
  logic [31:0]     rx_q;
  logic [CW-1:0]   tmo_cnt;
  logic            is_access;
  logic            apb_done;

  // Search starts one past the last grant so every client gets a turn.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!arb_hit && req[(int'(grant) + k) % NREQ]) begin
        arb_hit = 1'b1;
        arb_idx = GW'((int'(grant) + k) % NREQ);
      end
    end
  end

  assign is_access = (state == S_WR_DIV) || (state == S_WR_SS) || (state == S_WR_TX) ||
                     (state == S_WR_CTRL) || (state == S_RD_RX) || (state == S_ABORT);
  assign apb_done  = is_access && (phase == PH_ACCESS) && m_pready;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state <= S_IDLE;
      phase <= PH_GAP;
    end else begin
      state <= next_state;
      phase <= next_phase;
    end
  end

  // A completed access always leaves one idle bus cycle before the next SETUP.
  always_comb begin
    next_state = state;
    next_phase = phase;
    case (state)
      S_IDLE: begin
        if (arb_hit) begin
          next_state = S_WR_DIV;
          next_phase = PH_SETUP;
        end
      end
      S_WAIT_IRQ: begin
        if (spi_irq) begin
          next_state = S_RD_RX;
          next_phase = PH_SETUP;
        end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
          next_state = S_ABORT;
          next_phase = PH_SETUP;
        end
      end
      S_RESP, S_ABORT_DONE: begin
        next_state = S_IDLE;
        next_phase = PH_GAP;
      end
      default: begin
        case (phase)
          PH_GAP:   next_phase = PH_SETUP;
          PH_SETUP: next_phase = PH_ACCESS;
          default: begin
            if (m_pready) begin
              next_phase = PH_GAP;
              case (state)
                S_WR_DIV:  next_state = S_WR_SS;
                S_WR_SS:   next_state = S_WR_TX;
                S_WR_TX:   next_state = S_WR_CTRL;
                S_WR_CTRL: next_state = S_WAIT_IRQ;
                S_RD_RX:   next_state = S_RESP;
                default:   next_state = S_ABORT_DONE;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    m_psel    = is_access && (phase != PH_GAP);
    m_penable = is_access && (phase == PH_ACCESS);
    m_paddr   = '0;
    m_pwdata  = '0;
    m_pwrite  = 1'b0;
    if (m_psel) begin
      case (state)
        S_WR_DIV: begin
          m_paddr  = ADDR_DIV;
          m_pwdata = {16'b0, div_q};
          m_pwrite = 1'b1;
        end
        S_WR_SS: begin
          m_paddr  = ADDR_SS;
          m_pwdata = {24'b0, ss_q};
          m_pwrite = 1'b1;
        end
        S_WR_TX: begin
          m_paddr  = ADDR_RX0_TX0;
          m_pwdata = data_q;
          m_pwrite = 1'b1;
        end
        S_WR_CTRL: begin
          m_paddr  = ADDR_CTRL;
          m_pwdata = {18'b0, 1'b1, 1'b1, mode_q, 1'b1, 1'b0, len_q};
          m_pwrite = 1'b1;
        end
        S_ABORT: begin
          m_paddr  = ADDR_CTRL;
          m_pwdata = 32'h0000_2000;
          m_pwrite = 1'b1;
        end
        default: begin
          m_paddr  = ADDR_RX0_TX0;
          m_pwrite = 1'b0;
        end
      endcase
    end
  end

  // Everything a transfer needs is snapshotted at grant so clients may change inputs freely afterwards.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      grant   <= '0;
      data_q  <= '0;
      ss_q    <= '0;
      len_q   <= '0;
      div_q   <= '0;
      mode_q  <= '0;
      rx_q    <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_IDLE && arb_hit) begin
        grant  <= arb_idx;
        data_q <= req_data[32*arb_idx +: 32];
        ss_q   <= req_ss[8*arb_idx +: 8];
        len_q  <= req_len[7*arb_idx +: 7];
        div_q  <= cfg_div;
        mode_q <= cfg_mode;
        rx_q   <= '0;
      end
      if (state == S_RD_RX && apb_done) begin
        rx_q <= m_prdata;
      end
      if (state == S_WAIT_IRQ) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign err      = (state == S_ABORT_DONE);
  assign done     = (state == S_RESP || state == S_ABORT_DONE) ? (NREQ'(1) << grant) : '0;
  assign rsp_data = (state == S_RESP) ? rx_q : '0;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Scoreboard bench for spi_xfer_sched: an APB slave / SPI core model checks the register
// sequence, response words, round-robin order, timeout abort and mid-transfer reset.
module tb_spi_xfer_sched;

  localparam int         NREQ     = 2;
  localparam int         TMO      = 16;
  localparam logic [4:0] A_RXTX   = 5'h00;
  localparam logic [4:0] A_CTRL   = 5'h10;
  localparam logic [4:0] A_DIV    = 5'h14;
  localparam logic [4:0] A_SS     = 5'h18;

  logic                 PCLK = 1'b0;
  logic                 PRESETN = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*32-1:0]   req_data = '0;
  logic [NREQ*8-1:0]    req_ss = '0;
  logic [NREQ*7-1:0]    req_len = '0;
  logic [15:0]          cfg_div = '0;
  logic [2:0]           cfg_mode = '0;
  logic [NREQ-1:0]      done;
  logic                 err;
  logic [31:0]          rsp_data;
  logic                 busy;
  logic [4:0]           m_paddr;
  logic [31:0]          m_pwdata;
  logic                 m_pwrite;
  logic                 m_psel;
  logic                 m_penable;
  logic [31:0]          m_prdata = '0;
  logic                 m_pready = 1'b0;
  logic                 spi_irq = 1'b0;

  typedef struct { logic [4:0] addr; logic write; logic [31:0] data; } apb_op_t;
  typedef struct { int idx; logic err; logic [31:0] data; } rsp_t;

  apb_op_t exp_ops[$];
  rsp_t    exp_done[$];

  int checks = 0;
  int errors = 0;
  int wait_states = 0;
  int irq_enable = 1;
  int expected_wait = -1;
  int wait_cnt = 0;
  int irq_cnt = 0;
  int wait_cycles = 0;
  logic wait_count_on = 1'b0;
  logic prev_complete = 1'b0;
  logic prev_done = 1'b0;
  logic [4:0]  setup_addr = '0;
  logic [31:0] setup_data = '0;
  logic        setup_write = 1'b0;
  logic [31:0] tx0 = '0;
  logic [31:0] rx0 = '0;

  spi_xfer_sched #(
    .NREQ(NREQ), .TIMEOUT(TMO),
    .ADDR_RX0_TX0(A_RXTX), .ADDR_CTRL(A_CTRL), .ADDR_DIV(A_DIV), .ADDR_SS(A_SS)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .req(req), .req_data(req_data), .req_ss(req_ss), .req_len(req_len),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .done(done), .err(err), .rsp_data(rsp_data), .busy(busy),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
    .m_psel(m_psel), .m_penable(m_penable),
    .m_prdata(m_prdata), .m_pready(m_pready), .spi_irq(spi_irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] echo_mask(input logic [6:0] len);
    logic [31:0] one;
    one = 32'h1;
    if (len == 7'd0 || len >= 7'd32) return 32'hFFFF_FFFF;
    return (one << len) - 32'h1;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic [6:0] len, input logic [2:0] mode);
    return {18'b0, 1'b1, 1'b1, mode, 1'b1, 1'b0, len};
  endfunction

  task automatic push_write(input logic [4:0] addr, input logic [31:0] data);
    exp_ops.push_back('{addr, 1'b1, data});
  endtask

  task automatic push_transfer(input int idx, input logic [31:0] data, input logic [7:0] ss,
                               input logic [6:0] len, input logic [15:0] div,
                               input logic [2:0] mode, input bit timeout);
    push_write(A_DIV, {16'b0, div});
    push_write(A_SS, {24'b0, ss});
    push_write(A_RXTX, data);
    push_write(A_CTRL, ctrl_word(len, mode));
    if (timeout) begin
      push_write(A_CTRL, 32'h0000_2000);
      exp_done.push_back('{idx, 1'b1, 32'h0});
    end else begin
      exp_ops.push_back('{A_RXTX, 1'b0, 32'h0});
      exp_done.push_back('{idx, 1'b0, data & echo_mask(len)});
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [31:0] data, input logic [7:0] ss,
                                input logic [6:0] len);
    req_data[32*idx +: 32] = data;
    req_ss[8*idx +: 8]     = ss;
    req_len[7*idx +: 7]    = len;
    req[idx]               = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_done"}, 32'(done), 32'h0);
    check_output({tag, "_err"}, 32'(err), 32'h0);
    check_output({tag, "_rsp"}, rsp_data, 32'h0);
    check_output({tag, "_busy"}, 32'(busy), 32'h0);
    check_output({tag, "_paddr"}, 32'(m_paddr), 32'h0);
    check_output({tag, "_pwdata"}, m_pwdata, 32'h0);
    check_output({tag, "_ctl"}, {29'b0, m_pwrite, m_psel, m_penable}, 32'h0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge PCLK);
      #1;
      if (exp_ops.size() == 0 && exp_done.size() == 0 && !busy && req == '0) ok = 1'b1;
    end
    check_output({tag, "_idle"}, 32'(ok), 32'h1);
  endtask

  task automatic complete_transfer();
    apb_op_t e;
    check_output("apb_pending", 32'(exp_ops.size() != 0), 32'h1);
    if (exp_ops.size() != 0) begin
      e = exp_ops.pop_front();
      check_output("apb_addr", 32'(m_paddr), 32'(e.addr));
      check_output("apb_write", 32'(m_pwrite), 32'(e.write));
      if (e.write) check_output("apb_wdata", m_pwdata, e.data);
    end
    if (m_pwrite && m_paddr == A_RXTX) tx0 = m_pwdata;
    if (m_pwrite && m_paddr == A_CTRL && m_pwdata[8]) begin
      rx0 = tx0 & echo_mask(m_pwdata[6:0]);
      irq_cnt = (irq_enable != 0) ? 3 : 0;
      wait_count_on = 1'b1;
      wait_cycles = 0;
    end
    if (!m_pwrite && m_paddr == A_RXTX) begin
      m_prdata = rx0;
      spi_irq = 1'b0;
    end
  endtask

  // APB slave, SPI core echo model and response monitor, all evaluated on the falling edge.
  always @(negedge PCLK) begin
    rsp_t r;
    if (!PRESETN) begin
      m_pready = 1'b0;
      wait_cnt = 0;
      spi_irq = 1'b0;
      irq_cnt = 0;
      wait_count_on = 1'b0;
      prev_complete = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_complete) check_output("psel_drop", {30'b0, m_psel, m_penable}, 32'h0);
      prev_complete = 1'b0;
      if (prev_done) begin
        check_output("done_one_cycle", 32'(done), 32'h0);
        check_output("busy_gap", 32'(busy), 32'h0);
      end
      prev_done = 1'b0;
      if (done != '0) begin
        check_output("done_pending", 32'(exp_done.size() != 0), 32'h1);
        if (exp_done.size() != 0) begin
          r = exp_done.pop_front();
          check_output("done_vec", 32'(done), 32'h1 << r.idx);
          check_output("done_err", 32'(err), 32'(r.err));
          check_output("rsp_data", rsp_data, r.data);
        end
        check_output("busy_at_done", 32'(busy), 32'h1);
        req = req & ~done;
        prev_done = 1'b1;
      end
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) spi_irq = 1'b1;
      end
      if (wait_count_on) begin
        if (m_psel) begin
          if (expected_wait >= 0) check_output("wait_irq_cycles", wait_cycles, expected_wait);
          wait_count_on = 1'b0;
        end else begin
          wait_cycles++;
        end
      end
      if (m_psel && !m_penable) begin
        setup_addr = m_paddr;
        setup_data = m_pwdata;
        setup_write = m_pwrite;
        m_pready = 1'b0;
        wait_cnt = 0;
      end else if (m_psel && m_penable) begin
        check_output("stable_addr", 32'(m_paddr), 32'(setup_addr));
        check_output("stable_write", 32'(m_pwrite), 32'(setup_write));
        if (setup_write) check_output("stable_wdata", m_pwdata, setup_data);
        if (wait_cnt < wait_states) begin
          m_pready = 1'b0;
          wait_cnt++;
        end else begin
          m_pready = 1'b1;
          prev_complete = 1'b1;
          complete_transfer();
        end
      end else begin
        m_pready = 1'b0;
      end
    end
  end

  initial begin
    logic found;
    $display("[TB] start");
    repeat (3) @(posedge PCLK);
    #1;
    check_all_zero("reset");
    @(negedge PCLK);
    PRESETN = 1'b1;

    // Single client 0 with echo; inputs are scrambled after grant to prove they were latched.
    cfg_div = 16'd2;
    cfg_mode = 3'b000;
    exp_ops.push_back('{A_DIV, 1'b1, 32'h0000_0002});
    exp_ops.push_back('{A_SS, 1'b1, 32'h0000_0001});
    exp_ops.push_back('{A_RXTX, 1'b1, 32'hA5A5_00FF});
    exp_ops.push_back('{A_CTRL, 1'b1, 32'h0000_3108});
    exp_ops.push_back('{A_RXTX, 1'b0, 32'h0});
    exp_done.push_back('{0, 1'b0, 32'h0000_00FF});
    apply_stimulus(0, 32'hA5A5_00FF, 8'h01, 7'd8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge PCLK);
      #1;
      found = busy;
    end
    check_output("busy_rise", 32'(found), 32'h1);
    req_data[31:0] = 32'hDEAD_BEEF;
    req_ss[7:0] = 8'hEE;
    cfg_div = 16'h0055;
    cfg_mode = 3'b111;
    wait_idle("single", 400);

    // Both clients at once, twice: order must alternate 1,0,1,0.
    cfg_div = 16'd7;
    cfg_mode = 3'b101;
    push_transfer(1, 32'h1234_5678, 8'h02, 7'd16, 16'd7, 3'b101, 1'b0);
    push_transfer(0, 32'h0BAD_CAFE, 8'h01, 7'd12, 16'd7, 3'b101, 1'b0);
    apply_stimulus(0, 32'h0BAD_CAFE, 8'h01, 7'd12);
    apply_stimulus(1, 32'h1234_5678, 8'h02, 7'd16);
    wait_idle("rr_a", 800);
    cfg_mode = 3'b010;
    push_transfer(1, 32'hFEDC_BA98, 8'h80, 7'd4, 16'd7, 3'b010, 1'b0);
    push_transfer(0, 32'h7654_3210, 8'h10, 7'd20, 16'd7, 3'b010, 1'b0);
    apply_stimulus(0, 32'h7654_3210, 8'h10, 7'd20);
    apply_stimulus(1, 32'hFEDC_BA98, 8'h80, 7'd4);
    wait_idle("rr_b", 800);

    // Three wait states per access; len 0 returns the full word.
    wait_states = 3;
    cfg_div = 16'h1234;
    cfg_mode = 3'b100;
    push_transfer(0, 32'hC0FF_EE11, 8'h0F, 7'd0, 16'h1234, 3'b100, 1'b0);
    apply_stimulus(0, 32'hC0FF_EE11, 8'h0F, 7'd0);
    wait_idle("wstate", 800);
    wait_states = 0;

    // Core never interrupts: abort after exactly TMO cycles of waiting.
    irq_enable = 0;
    expected_wait = TMO;
    cfg_div = 16'd3;
    cfg_mode = 3'b001;
    push_transfer(1, 32'h5555_AAAA, 8'h20, 7'd32, 16'd3, 3'b001, 1'b1);
    apply_stimulus(1, 32'h5555_AAAA, 8'h20, 7'd32);
    wait_idle("timeout", 400);
    irq_enable = 1;
    expected_wait = -1;

    // Reset during the TX write; afterwards the pointer is back at 0 so client 1 wins first.
    cfg_div = 16'd9;
    cfg_mode = 3'b000;
    push_write(A_DIV, 32'h0000_0009);
    push_write(A_SS, 32'h0000_0004);
    apply_stimulus(1, 32'h1357_9BDF, 8'h04, 7'd16);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge PCLK);
      #2;
      if (m_psel && m_penable && m_pwrite && m_paddr == A_RXTX) found = 1'b1;
    end
    check_output("reach_wr_tx", 32'(found), 32'h1);
    PRESETN = 1'b0;
    #1;
    check_all_zero("midreset");
    check_output("pre_reset_ops", exp_ops.size(), 32'h0);
    exp_ops.delete();
    exp_done.delete();
    apply_stimulus(0, 32'h2468_ACE0, 8'h08, 7'd24);
    push_transfer(1, 32'h1357_9BDF, 8'h04, 7'd16, 16'd9, 3'b000, 1'b0);
    push_transfer(0, 32'h2468_ACE0, 8'h08, 7'd24, 16'd9, 3'b000, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    wait_idle("restart", 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
